// File: rtl/rptr_empty_pkg.sv
// Purpose : shared FIFO sizing defaults used by both read-side and write-side pointer blocks.
// Latency : n/a (parameters only).
// Backpressure: n/a.
package rptr_empty_pkg;

    // FIFO depth is 2**FIFO_ADDRSIZE; pointers carry one extra wrap bit.
    localparam int FIFO_ADDRSIZE      = 4;

    // Almost-empty asserts when occupancy is at or below this level.
    localparam int FIFO_AEMPTY_THRESH = 2;

endpackage : rptr_empty_pkg

// File: rtl/rptr_empty_gray2bin.sv
// Purpose : combinational Gray-to-binary converter, shared by read-empty and write-full logic.
// Latency : zero cycles (pure combinational).
// Backpressure: none; output follows input.
module gray2bin #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Each binary bit is the XOR of all Gray bits at or above its position.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^(gray >> i);
    end

endmodule : gray2bin

// File: rtl/rptr_empty.sv
// Purpose : async-FIFO read pointer, empty/almost-empty flags, occupancy and sticky underflow.
// Latency : flags and level update one rclk after a read; raddr is combinational from the register.
// Backpressure: reads while empty are ignored (pointer holds) and latch rerr_underflow.
module rptr_empty
    import rptr_empty_pkg::*;
#(
    parameter int ADDRSIZE      = FIFO_ADDRSIZE,
    parameter int AEMPTY_THRESH = FIFO_AEMPTY_THRESH
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                rinc,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    input  logic                rerr_clr,
    output logic [ADDRSIZE:0]   rptr,
    output logic [ADDRSIZE-1:0] raddr,
    output logic                rempty,
    output logic                raempty,
    output logic [ADDRSIZE:0]   rlevel,
    output logic                rerr_underflow
);

    localparam int            PW     = ADDRSIZE + 1;
    localparam logic [PW-1:0] THRESH = PW'(AEMPTY_THRESH);

    logic [PW-1:0] rbin_q,   rbin_d;
    logic [PW-1:0] rptr_q,   rptr_d;
    logic [PW-1:0] rlevel_q, rlevel_d;
    logic          rempty_q, rempty_d;
    logic          raempty_q, raempty_d;
    logic          rerr_underflow_q, rerr_underflow_d;
    logic [PW-1:0] wbin;
    logic          rd_en;

    // Synchronized write pointer back to binary so occupancy is a plain subtraction.
    gray2bin #(.WIDTH(PW)) u_wptr_g2b (
        .gray (rq2_wptr),
        .bin  (wbin)
    );

    // Next-state: advance only on a non-empty read; flags look at the post-read pointer.
    always_comb begin
        rd_en            = rinc & ~rempty_q;
        rbin_d           = rbin_q + PW'(rd_en);
        rptr_d           = (rbin_d >> 1) ^ rbin_d;
        rlevel_d         = wbin - rbin_d;
        rempty_d         = (rptr_d == rq2_wptr);
        raempty_d        = (rlevel_d <= THRESH);
        // A new underflow takes priority over a simultaneous clear.
        rerr_underflow_d = (rinc & rempty_q) | (rerr_underflow_q & ~rerr_clr);
    end

    // State registers; reset discards all read progress and reports empty.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_q           <= '0;
            rptr_q           <= '0;
            rlevel_q         <= '0;
            rempty_q         <= 1'b1;
            raempty_q        <= 1'b1;
            rerr_underflow_q <= 1'b0;
        end else begin
            rbin_q           <= rbin_d;
            rptr_q           <= rptr_d;
            rlevel_q         <= rlevel_d;
            rempty_q         <= rempty_d;
            raempty_q        <= raempty_d;
            rerr_underflow_q <= rerr_underflow_d;
        end
    end

    assign rptr           = rptr_q;
    assign raddr          = rbin_q[ADDRSIZE-1:0];
    assign rempty         = rempty_q;
    assign raempty        = raempty_q;
    assign rlevel         = rlevel_q;
    assign rerr_underflow = rerr_underflow_q;

endmodule : rptr_empty

// File: tb/tb_rptr_empty.sv
// Purpose : self-checking bench for rptr_empty with a count-based occupancy model.
// Latency : model mirrors one-cycle registered outputs.
// Backpressure: n/a.
module tb_rptr_empty;

    logic       rclk     = 1'b0;
    logic       rrst_n   = 1'b0;
    logic       rinc     = 1'b0;
    logic       rerr_clr = 1'b0;
    logic [4:0] rq2_wptr;
    logic [4:0] rptr;
    logic [3:0] raddr;
    logic       rempty;
    logic       raempty;
    logic [4:0] rlevel;
    logic       rerr_underflow;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int wcnt    = 0;

    always #5 rclk = ~rclk;

    function automatic logic [4:0] to_gray(input int v);
        logic [4:0] b;
        b = 5'(v % 32);
        return b ^ (b >> 1);
    endfunction

    always_comb rq2_wptr = to_gray(wcnt);

    rptr_empty #(.ADDRSIZE(4), .AEMPTY_THRESH(2)) dut (
        .rclk           (rclk),
        .rrst_n         (rrst_n),
        .rinc           (rinc),
        .rq2_wptr       (rq2_wptr),
        .rerr_clr       (rerr_clr),
        .rptr           (rptr),
        .raddr          (raddr),
        .rempty         (rempty),
        .raempty        (raempty),
        .rlevel         (rlevel),
        .rerr_underflow (rerr_underflow)
    );

    task automatic chk(input string name, input int act, input int exp);
        cmp_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a count of completed reads against the count of visible writes.
    int   m_rcnt;
    int   m_level;
    logic m_empty, m_aempty, m_err;
    logic m_rd;
    int   m_nr, m_lv;
    assign m_rd = rinc && !m_empty;
    assign m_nr = m_rcnt + (m_rd ? 1 : 0);
    assign m_lv = (((wcnt - m_nr) % 32) + 32) % 32;

    always @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            m_rcnt   <= 0;
            m_level  <= 0;
            m_empty  <= 1'b1;
            m_aempty <= 1'b1;
            m_err    <= 1'b0;
        end else begin
            m_rcnt   <= m_nr;
            m_level  <= m_lv;
            m_empty  <= (m_lv == 0);
            m_aempty <= (m_lv <= 2);
            m_err    <= (rinc && m_empty) ? 1'b1 : (rerr_clr ? 1'b0 : m_err);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    logic run = 1'b0;
    always @(negedge rclk) begin
        if (run) begin
            chk("m_rptr",   int'(rptr),           int'(to_gray(m_rcnt)));
            chk("m_raddr",  int'(raddr),          m_rcnt % 16);
            chk("m_rempty", int'(rempty),         int'(m_empty));
            chk("m_raempty",int'(raempty),        int'(m_aempty));
            chk("m_rlevel", int'(rlevel),         m_level);
            chk("m_uflow",  int'(rerr_underflow), int'(m_err));
        end
    end

    task automatic step;
        @(negedge rclk);
    endtask

    logic seen_hi;
    logic seen_wrap;
    int   empty_pulses;

    initial begin
        seen_hi = 1'b0; seen_wrap = 1'b0; empty_pulses = 0;
        // Reset state.
        run = 1'b1;
        step; step;
        chk("rst_rempty",  int'(rempty), 1);
        chk("rst_raempty", int'(raempty), 1);
        chk("rst_rptr",    int'(rptr), 0);
        chk("rst_rlevel",  int'(rlevel), 0);
        chk("rst_uflow",   int'(rerr_underflow), 0);
        rrst_n = 1'b1;
        step;

        // Fill to 3, drain with three reads.
        wcnt = 3;
        step;
        chk("fill_rlevel",  int'(rlevel), 3);
        chk("fill_rempty",  int'(rempty), 0);
        chk("fill_raempty", int'(raempty), 0);
        rinc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("drain_raddr", int'(raddr), i);
            step;
            if (i == 0) begin
                chk("drain1_raempty", int'(raempty), 1);
                chk("drain1_rlevel",  int'(rlevel), 2);
            end
        end
        rinc = 1'b0;
        chk("drain_rempty", int'(rempty), 1);
        chk("drain_rlevel", int'(rlevel), 0);
        chk("drain_rptr",   int'(rptr), 5'b00010);

        // Underflow: sticky, cleared by rerr_clr, set beats clear.
        rinc = 1'b1;
        step;
        rinc = 1'b0;
        chk("uf_rptr_hold", int'(rptr), 5'b00010);
        chk("uf_set",       int'(rerr_underflow), 1);
        step;
        chk("uf_hold",      int'(rerr_underflow), 1);
        rerr_clr = 1'b1;
        step;
        rerr_clr = 1'b0;
        chk("uf_clr",       int'(rerr_underflow), 0);
        rinc = 1'b1; rerr_clr = 1'b1;
        step;
        rinc = 1'b0; rerr_clr = 1'b0;
        chk("uf_set_wins",  int'(rerr_underflow), 1);
        chk("uf_rptr_hold2",int'(rptr), 5'b00010);

        // Full level from a fresh reset.
        rrst_n = 1'b0; wcnt = 0;
        step;
        rrst_n = 1'b1; wcnt = 16;
        step;
        chk("full_rlevel",  int'(rlevel), 16);
        chk("full_rempty",  int'(rempty), 0);
        chk("full_raempty", int'(raempty), 0);
        chk("full_rptr",    int'(rptr), 0);

        // Wrap: hold one entry in flight across 40 write/read pairs.
        rrst_n = 1'b0; wcnt = 0;
        step;
        rrst_n = 1'b1; wcnt = 1;
        step;
        rinc = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wcnt++;
            step;
            if (rptr[4]) seen_hi = 1'b1;
            else if (seen_hi) seen_wrap = 1'b1;
            if (rempty) empty_pulses++;
        end
        rinc = 1'b0;
        chk("wrap_raddr",    int'(raddr), 8);
        chk("wrap_rptr",     int'(rptr), 5'b01100);
        chk("wrap_rlevel",   int'(rlevel), 1);
        chk("wrap_msb_seen", int'(seen_hi & seen_wrap), 1);
        chk("wrap_no_empty", empty_pulses, 0);

        // Mid-operation asynchronous reset.
        wcnt = 5;
        rrst_n = 1'b0;
        step;
        rrst_n = 1'b1;
        step;
        chk("mid_pre_rlevel", int'(rlevel), 5);
        #2 rrst_n = 1'b0;
        #1;
        chk("mid_rempty",  int'(rempty), 1);
        chk("mid_raempty", int'(raempty), 1);
        chk("mid_rptr",    int'(rptr), 0);
        chk("mid_rlevel",  int'(rlevel), 0);
        chk("mid_uflow",   int'(rerr_underflow), 0);
        wcnt = 0;
        step;
        rrst_n = 1'b1;
        step;
        chk("post_rempty", int'(rempty), 1);
        chk("post_rlevel", int'(rlevel), 0);
        step;
        run = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule : tb_rptr_empty

// File: doc/rptr_empty.md
RPTR_EMPTY -- requirements
Module: rptr_empty

Interface
REQ-001 The block SHALL take parameter ADDRSIZE, default 4, meaning FIFO depth is 2^ADDRSIZE and pointers are ADDRSIZE+1 bits.
REQ-002 The block SHALL take parameter AEMPTY_THRESH, default 2, meaning raempty asserts when occupancy <= this value.
REQ-003 The block SHALL have port rclk, input, 1 bit: read-domain clock; the block has one clock, and all logic is rising-edge.
REQ-004 The block SHALL have port rrst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port rinc, input, 1 bit: read request for this cycle.
REQ-006 The block SHALL have port rq2_wptr, input, ADDRSIZE+1 bits: Gray write pointer, already two-flop synchronized into rclk.
REQ-007 The block SHALL have port rerr_clr, input, 1 bit: clears the sticky underflow flag.
REQ-008 The block SHALL have port rptr, output, ADDRSIZE+1 bits: registered Gray read pointer, sent to the write-side synchronizer.
REQ-009 The block SHALL have port raddr, output, ADDRSIZE bits: binary read address into the memory.
REQ-010 The block SHALL have port rempty, output, 1 bit: registered empty flag.
REQ-011 The block SHALL have port raempty, output, 1 bit: registered almost-empty flag.
REQ-012 The block SHALL have port rlevel, output, ADDRSIZE+1 bits: registered occupancy as seen from the read side, range 0..2^ADDRSIZE.
REQ-013 The block SHALL have port rerr_underflow, output, 1 bit: sticky flag for a read attempted while empty.

Function
REQ-014 The internal binary counter rbin (ADDRSIZE+1 bits) SHALL advance as rbinnext = rbin + (rinc & ~rempty), wrapping modulo 2^(ADDRSIZE+1).
REQ-015 The Gray next value SHALL be computed as rgraynext = (rbinnext >> 1) ^ rbinnext; rptr SHALL register rgraynext every cycle.
REQ-016 raddr SHALL equal rbin[ADDRSIZE-1:0], driven combinationally from the register so memory read latency is unchanged.
REQ-017 The next occupancy SHALL be computed as levnext = gray2bin(rq2_wptr) - rbinnext, modulo 2^(ADDRSIZE+1); rlevel SHALL register levnext.
REQ-018 rempty SHALL register (rgraynext == rq2_wptr), which is equivalent to levnext == 0.
REQ-019 raempty SHALL register (levnext <= AEMPTY_THRESH).
REQ-020 A read on an empty FIFO (rinc=1 while rempty=1) SHALL NOT move rbin or rptr, and SHALL set rerr_underflow on the next edge.
REQ-021 rerr_underflow SHALL hold until rerr_clr=1; if set and clear occur in the same cycle, set SHALL win.
REQ-022 A write becoming visible in rq2_wptr in the same cycle as the last read SHALL produce rempty = (rgraynext == rq2_wptr); no special case is needed.
REQ-023 Flag latency SHALL be one rclk after a read; a write SHALL be seen two rclk edges after wptr changes (synchronizer) plus one edge here.

Reset
REQ-024 On rrst_n=0, asynchronously: rbin=0, rptr=0, rempty=1, raempty=1, rlevel=0, rerr_underflow=0.
REQ-025 Reset asserted mid-transfer SHALL discard all read progress immediately; the first edge after release SHALL behave as if starting from empty.

Structure
REQ-026 ADDRSIZE and AEMPTY_THRESH defaults SHALL live in the shared FIFO parameter include, used together with the write-side blocks.
REQ-027 Gray-to-binary conversion SHALL be a combinational sub-module, gray2bin, parameterized by width; the write-side full logic reuses it.

Verification
REQ-028 Reset test: drive rrst_n=0 -> rempty=1, raempty=1, rptr=0, rlevel=0, rerr_underflow=0.
REQ-029 Fill and drain test: set rq2_wptr=5'b00010 (binary 3) -> next edge rlevel=3, rempty=0, raempty=0; then rinc=1 for 3 cycles -> raddr 0,1,2; raempty=1 after the first read, and rempty=1 with rlevel=0 after the third.
REQ-030 Underflow test: rinc=1 while empty -> rptr is unchanged, rerr_underflow=1 next edge and holds; rerr_clr=1 -> 0. Set and clear in the same cycle -> stays 1.
REQ-031 Full-level test: rbin=0 and rq2_wptr=5'b11000 (binary 16) -> rlevel=16, rempty=0, raempty=0.
REQ-032 Wrap test: stream 40 write/read pairs -> rbin wraps 31->0, the rptr MSB toggles, rlevel never exceeds 16, and there are no false rempty pulses while rlevel > 0.
REQ-033 Mid-operation reset test: pulse rrst_n low while rlevel=5 -> all outputs return to reset values asynchronously; after release with rq2_wptr=0, rempty remains 1.
